// File: rtl/ro_freq_counter.sv
// ro_freq_counter: counts rising edges of a ring-oscillator output over a
// programmable gate window and exposes control/results on a Wishbone slave.
//
// Ports:
//   wb_clk_i, wb_rst_i    single clock, synchronous active-high reset
//   ro_in                 muxed oscillator output (asynchronous)
//   ro_start              oscillator enable (CTRL.b1)
//   ro_stage[4:0]         stage selects s1..s5, bit0 = s1 (CTRL.b[12:8])
//   ro_sel[3:0]           output-mux select (CTRL.b[7:4])
//   wbs_*                 Wishbone slave; word registers at adr[3:2]:
//                         0 CTRL, 1 GATE, 2 STATUS, 3 COUNT
//
// Optional feature: define RO_FC_CONT_EN to implement CTRL.b3 (continuous
// measurement mode). Without it b3 reads 0 and DONE always returns to IDLE.

module ro_freq_counter #(
    parameter int CNT_W         = 32,
    parameter int GATE_W        = 24,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        ro_in,
    output logic        ro_start,
    output logic [4:0]  ro_stage,
    output logic [3:0]  ro_sel,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        GATE,
        DONE
    } state_t;

    state_t             state;
    logic [SET_W-1:0]   settle_cnt;
    logic [GATE_W-1:0]  gate_cnt;
    logic [GATE_W-1:0]  gate_len;
    logic [CNT_W-1:0]   edge_cnt;
    logic [CNT_W-1:0]   count_r;
    logic               ovf_flag;
    logic               done_r;
    logic               ovf_r;
    logic               go_p;
    logic               abort_p;
    logic               cont;

    logic               sync1;
    logic               sync2;
    logic               prev;
    logic               ro_edge;

    logic               wb_req;
    logic               wr;
    logic               rd;
    logic [1:0]         reg_idx;
    logic [31:0]        ctrl_rd;
    logic [31:0]        gate_ext;
    logic [31:0]        count_ext;
    logic [31:0]        status_rd;
    logic [31:0]        rd_mux;
    logic [31:0]        ctrl_wr;
    logic [31:0]        gate_wr;
    logic               busy;
    logic               unused_bits;

    // Per-byte merge of write data into the current register image.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

    assign wb_req  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr      = wb_req & wbs_we_i;
    assign rd      = wb_req & ~wbs_we_i;
    assign reg_idx = wbs_adr_i[3:2];
    assign busy    = (state != IDLE);
    assign ro_edge = sync2 & ~prev;

    always_comb begin
        gate_ext = '0;
        gate_ext[GATE_W-1:0] = gate_len;
        count_ext = '0;
        count_ext[CNT_W-1:0] = count_r;
        // go/abort are pulses and always read back as 0
        ctrl_rd = {19'd0, ro_stage, ro_sel, cont, 1'b0, ro_start, 1'b0};
        status_rd = {29'd0, ovf_r, done_r, busy};
        ctrl_wr = byte_merge(ctrl_rd, wbs_dat_i, wbs_sel_i);
        gate_wr = byte_merge(gate_ext, wbs_dat_i, wbs_sel_i);
        rd_mux = '0;
        case (reg_idx)
            2'd0: rd_mux = ctrl_rd;
            2'd1: rd_mux = gate_ext;
            2'd2: rd_mux = status_rd;
            2'd3: rd_mux = count_ext;
            default: rd_mux = '0;
        endcase
    end

    assign unused_bits = ^{wbs_adr_i, ctrl_wr, gate_wr};

`ifndef RO_FC_CONT_EN
    assign cont = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            ro_start   <= 1'b0;
            ro_sel     <= '0;
            ro_stage   <= '0;
`ifdef RO_FC_CONT_EN
            cont       <= 1'b0;
`endif
            gate_len   <= '0;
            go_p       <= 1'b0;
            abort_p    <= 1'b0;
            done_r     <= 1'b0;
            ovf_r      <= 1'b0;
            count_r    <= '0;
            state      <= IDLE;
            settle_cnt <= '0;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf_flag   <= 1'b0;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            prev       <= 1'b0;
        end else begin
            sync1 <= ro_in;
            sync2 <= sync1;
            prev  <= sync2;

            wbs_ack_o <= wb_req;
            wbs_dat_o <= rd ? rd_mux : '0;

            go_p    <= wr && (reg_idx == 2'd0) && ctrl_wr[0];
            abort_p <= wr && (reg_idx == 2'd0) && ctrl_wr[2];

            if (wr && reg_idx == 2'd0) begin
                ro_start <= ctrl_wr[1];
                ro_sel   <= ctrl_wr[7:4];
                ro_stage <= ctrl_wr[12:8];
`ifdef RO_FC_CONT_EN
                cont     <= ctrl_wr[3];
`endif
            end
            if (wr && reg_idx == 2'd1) begin
                gate_len <= gate_wr[GATE_W-1:0];
            end

            // Read-to-clear; a DONE in the same cycle overrides below.
            if (rd && reg_idx == 2'd2) begin
                done_r <= 1'b0;
                ovf_r  <= 1'b0;
            end

            if (abort_p) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (go_p) begin
                            edge_cnt <= '0;
                            ovf_flag <= 1'b0;
                            if (gate_len != '0) begin
                                done_r     <= 1'b0;
                                ovf_r      <= 1'b0;
                                settle_cnt <= SET_LOAD;
                                state      <= SETTLE;
                            end else begin
                                state <= DONE;
                            end
                        end
                    end
                    SETTLE: begin
                        if (settle_cnt == '0) begin
                            edge_cnt <= '0;
                            ovf_flag <= 1'b0;
                            gate_cnt <= gate_len;
                            // GATE rewritten to 0 while looping: empty window
                            state    <= (gate_len == '0) ? DONE : GATE;
                        end else begin
                            settle_cnt <= settle_cnt - 1'b1;
                        end
                    end
                    GATE: begin
                        if (ro_edge) begin
                            if (edge_cnt == {CNT_W{1'b1}}) begin
                                ovf_flag <= 1'b1;
                            end else begin
                                edge_cnt <= edge_cnt + 1'b1;
                            end
                        end
                        if (gate_cnt == GATE_W'(1)) begin
                            state <= DONE;
                        end else begin
                            gate_cnt <= gate_cnt - 1'b1;
                        end
                    end
                    DONE: begin
                        count_r <= edge_cnt;
                        done_r  <= 1'b1;
                        ovf_r   <= ovf_flag;
                        if (cont && gate_len != '0) begin
                            settle_cnt <= SET_LOAD;
                            state      <= SETTLE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ro_freq_counter.sv
// tb_ro_freq_counter: scoreboard bench for ro_freq_counter.
// Reads queue their expected value; the ack monitor pops and compares.

module tb_ro_freq_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ro_in = 1'b0;
    logic        ro_start;
    logic [4:0]  ro_stage;
    logic [3:0]  ro_sel;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = '0;
    logic [31:0] wbs_dat_i = '0;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;

    int n_checks = 0;
    int n_err = 0;
    int cyc_n = 0;
    int last_ack = 0;
    int ro_div = 0;
    int ph = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        int          tol;
    } sb_t;

    sb_t sb[$];
    sb_t ent;

    ro_freq_counter #(
        .CNT_W(8),
        .GATE_W(24),
        .SETTLE_CYCLES(4)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .ro_in(ro_in),
        .ro_start(ro_start),
        .ro_stage(ro_stage),
        .ro_sel(ro_sel),
        .wbs_cyc_i(wbs_cyc_i),
        .wbs_stb_i(wbs_stb_i),
        .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i),
        .wbs_dat_i(wbs_dat_i),
        .wbs_dat_o(wbs_dat_o),
        .wbs_ack_o(wbs_ack_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Oscillator model: toggles every ro_div cycles, 2 time units after
    // the clock edge so it never races the synchronizer.
    always @(posedge clk) begin
        #2;
        if (ro_div == 0) begin
            ro_in = 1'b0;
            ph = 0;
        end else begin
            ph = ph + 1;
            if (ph >= ro_div) begin
                ph = 0;
                ro_in = ~ro_in;
            end
        end
    end

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp,
        input int          tol = 0
    );
        logic [31:0] d;
        n_checks++;
        d = (got > exp) ? got - exp : exp - got;
        if ($isunknown(got) || d > 32'(tol)) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (tol %0d)",
                     tag, got, exp, tol);
        end
    endtask

    always @(negedge clk) begin
        if (wbs_ack_o && !wbs_we_i) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                ent = sb.pop_front();
                check(ent.tag, wbs_dat_o, ent.exp, ent.tol);
            end
        end
    end

    task automatic wait_at(input int at);
        @(negedge clk);
        while (at >= 0 && cyc_n < at) @(negedge clk);
    endtask

    task automatic bus(
        input  logic        we,
        input  logic [31:0] adr,
        input  logic [31:0] dat,
        input  logic [3:0]  sel,
        input  int          at,
        output bit          ok
    );
        wait_at(at);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wbs_ack_o) begin
                ok = 1'b1;
                break;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        last_ack = cyc_n;
    endtask

    task automatic wr(
        input logic [31:0] adr,
        input logic [31:0] dat,
        input logic [3:0]  sel = 4'hF,
        input int          at = -1
    );
        bit ok;
        bus(1'b1, adr, dat, sel, at, ok);
        if (!ok) check("wr_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic rd(
        input logic [31:0] adr,
        input string       tag,
        input logic [31:0] exp,
        input int          tol = 0,
        input int          at = -1
    );
        bit ok;
        sb.push_back('{tag, exp, tol});
        bus(1'b0, adr, 32'd0, 4'hF, at, ok);
        if (!ok) begin
            sb.delete(sb.size() - 1);
            check({tag, "_ack_timeout"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int t2;

        repeat (3) @(negedge clk);
        check("rst_ack", 32'(wbs_ack_o), 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_ro", {26'd0, ro_start, ro_sel, ro_stage}, 32'd0);
        rst = 1'b0;
        rd(32'h8, "rst_status", 32'd0);
        rd(32'hC, "rst_count", 32'd0);
        rd(32'h4, "rst_gate", 32'd0);
        rd(32'h0, "rst_ctrl", 32'd0);

        // clk/4 input, GATE=100
        ro_div = 2;
        wr(32'h4, 32'd100);
        wr(32'h0, 32'h1);
        t = last_ack;
        rd(32'h8, "t1_busy_start", 32'h1, 0, t + 1);
        rd(32'h8, "t1_busy_gate", 32'h1, 0, t + 104);
        rd(32'h8, "t1_done", 32'h2, 0, t + 106);
        rd(32'h8, "t1_clr", 32'h0);
        rd(32'hC, "t1_count", 32'd25, 1);

        // GATE=0: straight to DONE
        wr(32'h4, 32'd0);
        wr(32'h0, 32'h1);
        t = last_ack;
        rd(32'h8, "t2_done", 32'h2, 0, t + 2);
        rd(32'hC, "t2_count", 32'd0);

        // clk/2 input saturates the 8-bit counter
        ro_div = 1;
        wr(32'h4, 32'd1000);
        wr(32'h0, 32'h1);
        t = last_ack;
        rd(32'h8, "t3_set_wins", 32'h1, 0, t + 1005);
        rd(32'h8, "t3_status", 32'h6, 0, t + 1007);
        rd(32'h8, "t3_clr", 32'h0);
        rd(32'hC, "t3_count", 32'd255);
        wr(32'hC, 32'd0);
        rd(32'hC, "ro_count", 32'd255);
        wr(32'h8, 32'h7);
        rd(32'h8, "ro_status", 32'h0);

        // oscillator drive fields and abort
        ro_div = 2;
        wr(32'h4, 32'd100);
        wr(32'h0, 32'h0000_1F32);
        @(negedge clk);
        check("ack_pulse", 32'(wbs_ack_o), 32'd0);
        check("ro_start", 32'(ro_start), 32'd1);
        check("ro_sel", 32'(ro_sel), 32'd3);
        check("ro_stage", 32'(ro_stage), 32'h1F);
        rd(32'h0, "t4_ctrl", 32'h1F32);
        wr(32'h0, 32'h0000_1F33);
        t = last_ack;
        wr(32'h0, 32'h0000_1F36, 4'hF, t + 54);
        t2 = last_ack;
        rd(32'h8, "t4_abort", 32'h0, 0, t2 + 1);
        rd(32'hC, "t4_count", 32'd255);
        rd(32'h0, "t4_ctrl2", 32'h1F32);

        // abort and go together: abort wins
        wr(32'h0, 32'h5);
        t = last_ack;
        rd(32'h8, "go_abort", 32'h0, 0, t + 1);

        // reset mid-GATE
        wr(32'h0, 32'h0000_1F33);
        t = last_ack;
        wait_at(t + 40);
        rst = 1'b1;
        @(negedge clk);
        check("t5_ack", 32'(wbs_ack_o), 32'd0);
        check("t5_dat", wbs_dat_o, 32'd0);
        check("t5_ro", {26'd0, ro_start, ro_sel, ro_stage}, 32'd0);
        rst = 1'b0;
        rd(32'h8, "t5_status", 32'h0);
        rd(32'hC, "t5_count0", 32'd0);
        rd(32'h4, "t5_gate0", 32'd0);
        wr(32'h4, 32'd20);
        wr(32'h0, 32'h1);
        t = last_ack;
        rd(32'h8, "t5_done", 32'h2, 0, t + 26);
        rd(32'hC, "t5_count", 32'd5, 1);

        // byte enables on GATE
        wr(32'h4, 32'hFFFF_FF05, 4'b0001);
        rd(32'h4, "be_b0", 32'h05);
        wr(32'h4, 32'h00AB_0000, 4'b0100);
        rd(32'h4, "be_b2", 32'hAB0005);
        wr(32'h4, 32'hFF00_0000, 4'b1000);
        rd(32'h4, "be_b3", 32'hAB0005);

`ifdef RO_FC_CONT_EN
        // continuous mode, clk/8 input, GATE=40: DONE every 45 cycles
        ro_div = 4;
        wr(32'h4, 32'd40);
        wr(32'h0, 32'h9);
        t = last_ack;
        rd(32'h8, "c_done1", 32'h3, 0, t + 46);
        rd(32'hC, "c_count1", 32'd5, 1, t + 48);
        rd(32'h8, "c_done2", 32'h3, 0, t + 91);
        rd(32'hC, "c_count2", 32'd5, 1, t + 93);
        rd(32'h8, "c_done3", 32'h3, 0, t + 136);
        rd(32'hC, "c_count3", 32'd5, 1, t + 138);
        wr(32'h0, 32'h0, 4'hF, t + 140);
        rd(32'h8, "c_last_busy", 32'h1, 0, t + 179);
        rd(32'h8, "c_stop", 32'h2, 0, t + 181);
        rd(32'hC, "c_count4", 32'd5, 1);
`else
        wr(32'h0, 32'h8);
        rd(32'h0, "no_cont", 32'h0);
`endif

        repeat (4) @(negedge clk);
        if (sb.size() != 0) check("sb_leftover", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
